// File: rtl/mac_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_accumulator_if
// Description : Product-stream input and result output bundle for
//               mac_accumulator.
//   in_valid/in_ready/in_data       : product stream (master -> slave)
//   out_valid/out_ready/out_data    : result port    (slave -> master)
//   out_ovf                         : result overflowed during its group
//   cnt                             : products accepted in current group
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_accumulator_if #(
  parameter int IN_W  = 9,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;
  logic [CNT_W-1:0] cnt;

  // Upstream sequencer / downstream consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, cnt
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, cnt
  );
endinterface
`default_nettype wire

// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : mac_accumulator
// Description : Sums each group of ACC_LEN consecutive unsigned products into
//               one ACC_W-bit result, presented on a valid/ready port together
//               with an overflow flag. A pending result may retire in the same
//               cycle that the first product of the next group is accepted,
//               giving one product per cycle sustained throughput.
// Ports       : clk   - clock, rising edge
//               rst_n - synchronous reset, active-high (asserted = 1)
//               clear - synchronous abort of the partial accumulation
//               bus   - mac_accumulator_if.slave (stream in, result out, cnt)
// Config      : MAC_ACCUMULATOR_SATURATE_EN - when defined, the accumulator
//               clamps at 2^ACC_W-1 after an overflow instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_accumulator #(
  parameter int IN_W    = 9,
  parameter int ACC_W   = 12,
  parameter int ACC_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          clear,
  mac_accumulator_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ACC_LEN - 1);
  localparam logic [ACC_W-1:0] C_MAX  = '1;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_acc;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_data;
  logic             r_out_ovf;

  state_t           w_state_nx;
  logic [ACC_W-1:0] w_acc_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_ovf_acc_nx;
  logic             w_out_valid_nx;
  logic [ACC_W-1:0] w_out_data_nx;
  logic             w_out_ovf_nx;

  logic             w_in_ready;
  logic             w_accept;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf_next;
  logic [ACC_W-1:0] w_acc_next;

  // in_ready uses only registered state, out_ready and clear: no path from
  // in_valid/in_data, so upstream can safely wait on it.
  assign w_in_ready = ~clear & ((r_state == ST_ACCUM) | bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready & ~clear;

  // One extra bit captures the carry out of the accumulator.
  assign w_sum      = {1'b0, r_acc} + (ACC_W + 1)'(bus.in_data);
  assign w_ovf_next = r_ovf_acc | w_sum[ACC_W];

`ifdef MAC_ACCUMULATOR_SATURATE_EN
  // Clamp once overflow has been seen; further additions keep it at max.
  assign w_acc_next = w_ovf_next ? C_MAX : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  always_comb begin
    w_state_nx     = r_state;
    w_acc_nx       = r_acc;
    w_cnt_nx       = r_cnt;
    w_ovf_acc_nx   = r_ovf_acc;
    w_out_valid_nx = r_out_valid;
    w_out_data_nx  = r_out_data;
    w_out_ovf_nx   = r_out_ovf;

    case (r_state)
      ST_ACCUM: begin
        if (clear) begin
          w_acc_nx     = '0;
          w_cnt_nx     = '0;
          w_ovf_acc_nx = 1'b0;
        end else if (w_accept) begin
          if (r_cnt == C_LAST) begin
            w_out_data_nx  = w_acc_next;
            w_out_ovf_nx   = w_ovf_next;
            w_out_valid_nx = 1'b1;
            w_acc_nx       = '0;
            w_cnt_nx       = '0;
            w_ovf_acc_nx   = 1'b0;
            w_state_nx     = ST_HOLD;
          end else begin
            w_acc_nx     = w_acc_next;
            w_cnt_nx     = r_cnt + CNT_W'(1);
            w_ovf_acc_nx = w_ovf_next;
          end
        end
      end

      ST_HOLD: begin
        if (bus.out_ready) begin
          w_out_valid_nx = 1'b0;
          w_state_nx     = ST_ACCUM;
          // The accumulator is already empty here, so the accepted product
          // simply becomes the first addend of the next group.
          if (w_accept) begin
            w_acc_nx     = w_acc_next;
            w_cnt_nx     = r_cnt + CNT_W'(1);
            w_ovf_acc_nx = w_ovf_next;
          end
        end
      end

      default: begin
        w_state_nx = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf_acc   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_acc       <= w_acc_nx;
      r_cnt       <= w_cnt_nx;
      r_ovf_acc   <= w_ovf_acc_nx;
      r_out_valid <= w_out_valid_nx;
      r_out_data  <= w_out_data_nx;
      r_out_ovf   <= w_out_ovf_nx;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.cnt       = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_accumulator
// Description : Self-checking bench for mac_accumulator. A group-level model
//               (running total, product count, pending-result flag) is
//               compared against the DUT every cycle; directed scenarios add
//               hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_accumulator;

  localparam int IN_W    = 9;
  localparam int ACC_W   = 12;
  localparam int ACC_LEN = 16;
  localparam int CNT_W   = 8;
  localparam int MAXV    = (1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  mac_accumulator_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  mac_accumulator #(
    .IN_W(IN_W), .ACC_W(ACC_W), .ACC_LEN(ACC_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- group-level model ----------------
  bit m_live    = 0;
  bit m_pending = 0;
  int m_sum     = 0;     // unbounded running total of the current group
  int m_n       = 0;     // products in the current group
  int m_odata   = 0;
  int m_oovf    = 0;
  int handshakes = 0;

  always @(negedge clk) begin
    bit exp_rdy;
    bit acc_ok;
    exp_rdy = !clear && (!m_pending || bus.out_ready);
    acc_ok  = bus.in_valid && exp_rdy;
    if (m_live) begin
      chk("mdl_in_ready",  int'(bus.in_ready),  int'(exp_rdy));
      chk("mdl_out_valid", int'(bus.out_valid), int'(m_pending));
      chk("mdl_out_data",  int'(bus.out_data),  m_odata);
      chk("mdl_out_ovf",   int'(bus.out_ovf),   m_oovf);
      chk("mdl_cnt",       int'(bus.cnt),       m_n);
      if (bus.out_valid && bus.out_ready) handshakes++;
    end
    if (rst_n) begin
      m_live = 1; m_pending = 0; m_sum = 0; m_n = 0; m_odata = 0; m_oovf = 0;
    end else if (m_live) begin
      if (m_pending && bus.out_ready) m_pending = 0;
      if (clear && !m_pending) begin
        m_sum = 0; m_n = 0;
      end
      if (acc_ok) begin
        m_sum += int'(bus.in_data);
        m_n++;
        if (m_n == ACC_LEN) begin
          m_oovf = (m_sum > MAXV) ? 1 : 0;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
          m_odata = (m_sum > MAXV) ? MAXV : m_sum;
`else
          m_odata = m_sum % (MAXV + 1);
`endif
          m_pending = 1; m_sum = 0; m_n = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input int val);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = IN_W'(val);
      step();
    end
  endtask

  initial begin
    int hs0;
    rst_n = 1'b1; clear = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    step(); step();
    rst_n = 1'b0;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data",  int'(bus.out_data), 0);
    chk("rst_cnt",       int'(bus.cnt), 0);
    chk("rst_in_ready",  int'(bus.in_ready), 1);

    // 16 ones -> 16, no overflow, valid right after the 16th accept
    feed(15, 1);
    chk("ones_not_yet_valid", int'(bus.out_valid), 0);
    feed(1, 1);
    bus.in_valid = 1'b0;
    chk("ones_valid",   int'(bus.out_valid), 1);
    chk("ones_data",    int'(bus.out_data), 16);
    chk("ones_ovf",     int'(bus.out_ovf), 0);
    chk("ones_cnt",     int'(bus.cnt), 0);
    step();
    chk("ones_retired", int'(bus.out_valid), 0);

    // 16 x 511 -> overflow
    feed(16, 511);
    bus.in_valid = 1'b0;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
    chk("big_data", int'(bus.out_data), 4095);
`else
    chk("big_data", int'(bus.out_data), 4080);
`endif
    chk("big_ovf", int'(bus.out_ovf), 1);
    step();

    // Stall in HOLD, then back-to-back accept of the held 7
    bus.out_ready = 1'b0;
    feed(16, 2);
    bus.in_valid = 1'b1; bus.in_data = 9'd7;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", int'(bus.in_ready), 0);
      chk("stall_data",     int'(bus.out_data), 32);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", int'(bus.in_ready), 1);
    step();
    chk("b2b_cnt",   int'(bus.cnt), 1);
    chk("b2b_valid", int'(bus.out_valid), 0);
    feed(15, 7);
    bus.in_valid = 1'b0;
    chk("sevens_data", int'(bus.out_data), 112);
    chk("sevens_ovf",  int'(bus.out_ovf), 0);
    step();

    // clear after 9 accepts drops the concurrent product
    feed(9, 3);
    clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 9'd3;
    step();
    clear = 1'b0;
    chk("clear_cnt", int'(bus.cnt), 0);
    feed(16, 2);
    bus.in_valid = 1'b0;
    chk("after_clear_data", int'(bus.out_data), 32);
    step();

    // clear during HOLD: result retires, product not taken
    bus.out_ready = 1'b0;
    feed(16, 1);
    clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 9'd5; bus.out_ready = 1'b1;
    #1;
    chk("hold_clear_in_ready", int'(bus.in_ready), 0);
    step();
    clear = 1'b0; bus.in_valid = 1'b0;
    chk("hold_clear_valid", int'(bus.out_valid), 0);
    chk("hold_clear_cnt",   int'(bus.cnt), 0);

    // reset while a result is pending
    bus.out_ready = 1'b0;
    feed(16, 4);
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", int'(bus.out_valid), 1);
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    chk("hold_rst_valid",    int'(bus.out_valid), 0);
    chk("hold_rst_data",     int'(bus.out_data), 0);
    chk("hold_rst_cnt",      int'(bus.cnt), 0);
    chk("hold_rst_in_ready", int'(bus.in_ready), 1);

    // continuous random stream, 10 groups
    bus.out_ready = 1'b1;
    hs0 = handshakes;
    for (int i = 0; i < 10 * ACC_LEN; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = IN_W'($urandom_range(0, 511));
      step();
    end
    bus.in_valid = 1'b0;
    step();
    chk("stream_results", handshakes - hs0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
